// File: rtl/pixel_write_arbiter.sv
// Pixel write arbiter: merges the block-drawer and player-drawer pixel
// streams into a 4-deep FIFO and drains it one pixel per cycle into the
// VGA adapter write port. Off-screen pixels are accepted but dropped and counted.
module pixel_write_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       blk_valid,
  input  logic [7:0] blk_x,
  input  logic [6:0] blk_y,
  input  logic [2:0] blk_colour,
  output logic       blk_ready,
  input  logic       ply_valid,
  input  logic [7:0] ply_x,
  input  logic [6:0] ply_y,
  input  logic [2:0] ply_colour,
  output logic       ply_ready,
  input  logic       hold,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] drop_count,
  output logic [2:0] fifo_count
);

  typedef enum logic {
    PRI_BLK = 1'b0,
    PRI_PLY = 1'b1
  } pri_t;

  pri_t        pri;
  logic [17:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;

  logic        full;
  logic        empty;
  logic        contended;
  logic        accept;
  logic        in_range;
  logic        push;
  logic        pop;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_colour;

  // Grant selection: a port is ready only when it is valid and granted,
  // so ready doubles as the handshake strobe. Full blocks acceptance even
  // when a pop happens in the same cycle.
  always_comb begin
    full      = (fifo_count == 3'd4);
    empty     = (fifo_count == 3'd0);
    contended = blk_valid && ply_valid;
    blk_ready = 1'b0;
    ply_ready = 1'b0;
    if (reset && !full) begin
      if (contended) begin
        if (pri == PRI_BLK) blk_ready = 1'b1;
        else                ply_ready = 1'b1;
      end else begin
        blk_ready = blk_valid;
        ply_ready = ply_valid;
      end
    end
  end

  // Mux the granted pixel and classify it as on-screen or clipped.
  always_comb begin
    sel_x      = ply_ready ? ply_x      : blk_x;
    sel_y      = ply_ready ? ply_y      : blk_y;
    sel_colour = ply_ready ? ply_colour : blk_colour;
    accept     = blk_ready || ply_ready;
    in_range   = (sel_x < 8'd160) && (sel_y < 7'd120);
    push       = accept && in_range;
    pop        = !hold && !empty;
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {sel_x, sel_y, sel_colour};
  end

  // FIFO pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // VGA write port: load head entry and strobe plot on each pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (pop) begin
      {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
      vga_plot                   <= 1'b1;
    end else begin
      vga_plot <= 1'b0;
    end
  end

  // Saturating count of clipped pixels.
  always_ff @(posedge clock) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (accept && !in_range && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Round-robin pointer: flips only after a two-way contended grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pri <= PRI_BLK;
    end else if (accept && contended) begin
      pri <= (pri == PRI_BLK) ? PRI_PLY : PRI_BLK;
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: a cycle model predicts
// grants, occupancy and drops; accepted on-screen pixels go into a
// scoreboard queue and are compared when the DUT plots them.
module tb_pixel_write_arbiter;

  logic       clock;
  logic       reset;
  logic       blk_valid;
  logic [7:0] blk_x;
  logic [6:0] blk_y;
  logic [2:0] blk_colour;
  logic       blk_ready;
  logic       ply_valid;
  logic [7:0] ply_x;
  logic [6:0] ply_y;
  logic [2:0] ply_colour;
  logic       ply_ready;
  logic       hold;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [7:0] drop_count;
  logic [2:0] fifo_count;

  pixel_write_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .blk_valid  (blk_valid),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .blk_colour (blk_colour),
    .blk_ready  (blk_ready),
    .ply_valid  (ply_valid),
    .ply_x      (ply_x),
    .ply_y      (ply_y),
    .ply_colour (ply_colour),
    .ply_ready  (ply_ready),
    .hold       (hold),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .drop_count (drop_count),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [17:0] sb [$];
  int          m_count = 0;
  int          m_drop  = 0;
  bit          m_pri   = 1'b0;
  logic        last_b;
  logic        last_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: check combinational grants, advance the model across
  // the edge, then check registered outputs against the scoreboard.
  task automatic step();
    logic        exp_b, exp_p, cont, acc, inr, exp_plot, rst_now;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic [17:0] e;
    #1;
    cont  = blk_valid && ply_valid;
    exp_b = 1'b0;
    exp_p = 1'b0;
    if (reset && m_count < 4) begin
      if (cont) begin
        exp_b = !m_pri;
        exp_p = m_pri;
      end else begin
        exp_b = blk_valid;
        exp_p = ply_valid;
      end
    end
    check("blk_ready", blk_ready, exp_b);
    check("ply_ready", ply_ready, exp_p);
    last_b   = exp_b;
    last_p   = exp_p;
    x        = exp_p ? ply_x : blk_x;
    y        = exp_p ? ply_y : blk_y;
    c        = exp_p ? ply_colour : blk_colour;
    acc      = exp_b || exp_p;
    inr      = (x < 8'd160) && (y < 7'd120);
    exp_plot = 1'b0;
    rst_now  = !reset;
    if (rst_now) begin
      m_count = 0;
      m_drop  = 0;
      m_pri   = 1'b0;
      sb.delete();
    end else begin
      if (!hold && m_count > 0) begin
        exp_plot = 1'b1;
        m_count--;
      end
      if (acc && inr) begin
        sb.push_back({x, y, c});
        m_count++;
      end
      if (acc && !inr && m_drop < 255) m_drop++;
      if (acc && cont) m_pri = !m_pri;
    end
    @(posedge clock);
    #1;
    check("vga_plot", vga_plot, exp_plot);
    if (vga_plot) begin
      if (sb.size() == 0) begin
        check("plot_with_empty_sb", vga_plot, 0);
      end else begin
        e = sb.pop_front();
        check("vga_x", vga_x, e[17:10]);
        check("vga_y", vga_y, e[9:3]);
        check("vga_colour", vga_colour, e[2:0]);
      end
    end
    if (rst_now) begin
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_y", vga_y, 0);
      check("rst_vga_colour", vga_colour, 0);
    end
    check("fifo_count", fifo_count, m_count);
    check("drop_count", drop_count, m_drop);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0;
    blk_valid = 1'b0; blk_x = '0; blk_y = '0; blk_colour = '0;
    ply_valid = 1'b0; ply_x = '0; ply_y = '0; ply_colour = '0;

    // Reset state, with requests pending to confirm ready stays low.
    blk_valid = 1'b1; ply_valid = 1'b1;
    idle(2);
    blk_valid = 1'b0; ply_valid = 1'b0;
    reset = 1'b1;
    idle(1);

    // Single pixel: appears two edges after acceptance for one cycle.
    blk_valid = 1'b1; blk_x = 8'd20; blk_y = 7'd7; blk_colour = 3'b100;
    step();
    blk_valid = 1'b0;
    idle(4);

    // Contention: grants alternate, output order preserved.
    blk_valid = 1'b1; blk_x = 8'd1;   blk_y = 7'd1; blk_colour = 3'd1;
    ply_valid = 1'b1; ply_x = 8'd100; ply_y = 7'd50; ply_colour = 3'd6;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      if (last_b) begin blk_x = blk_x + 8'd3; blk_y = blk_y + 7'd2; blk_colour = blk_colour + 3'd1; end
      if (last_p) begin ply_x = ply_x + 8'd5; ply_y = ply_y + 7'd1; ply_colour = ply_colour - 3'd1; end
    end
    blk_valid = 1'b0; ply_valid = 1'b0;
    idle(5);

    // Full FIFO under hold; release while still requesting.
    hold = 1'b1; blk_valid = 1'b1; blk_x = 8'd30; blk_y = 7'd40; blk_colour = 3'd2;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      if (last_b) begin blk_x = blk_x + 8'd1; blk_colour = blk_colour + 3'd1; end
    end
    hold = 1'b0;
    step();
    blk_valid = 1'b0;
    idle(6);

    // Clipping on both axes, then saturation of the drop counter.
    ply_valid = 1'b1; ply_x = 8'd165; ply_y = 7'd10; ply_colour = 3'd3;
    step();
    ply_x = 8'd10; ply_y = 7'd120;
    step();
    ply_valid = 1'b0;
    idle(3);
    blk_valid = 1'b1; blk_x = 8'd200; blk_y = 7'd5;
    idle(300);
    blk_valid = 1'b0;
    idle(2);

    // Reset mid-operation with three buffered entries.
    hold = 1'b1; blk_valid = 1'b1; blk_x = 8'd70; blk_y = 7'd60; blk_colour = 3'd5;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      blk_x = blk_x + 8'd1;
    end
    reset = 1'b0;
    step();
    reset = 1'b1; hold = 1'b0; blk_valid = 1'b0;
    idle(5);

    // Random traffic with occasional hold and off-screen coordinates.
    for (int unsigned i = 0; i < 400; i++) begin
      blk_valid  = ($urandom_range(0, 3) != 0);
      ply_valid  = ($urandom_range(0, 3) != 0);
      hold       = ($urandom_range(0, 4) == 0);
      blk_x      = 8'($urandom_range(0, 175));
      blk_y      = 7'($urandom_range(0, 127));
      blk_colour = 3'($urandom_range(0, 7));
      ply_x      = 8'($urandom_range(0, 175));
      ply_y      = 7'($urandom_range(0, 127));
      ply_colour = 3'($urandom_range(0, 7));
      step();
    end
    blk_valid = 1'b0; ply_valid = 1'b0; hold = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have `clock`, input, 1 bit: system clock (50 MHz); all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have block drawer input port:
- `blk_valid` in 1
- `blk_x` in 8
- `blk_y` in 7
- `blk_colour` in 3
- `blk_ready` out 1: pixel accepted this cycle.
REQ-004 SHALL have player drawer input port:
- `ply_valid` in 1
- `ply_x` in 8
- `ply_y` in 7
- `ply_colour` in 3
- `ply_ready` out 1
REQ-005 SHALL have `hold`, input, 1 bit: stalls output draining, e.g. during screen clear.
REQ-006 SHALL have VGA adapter write port, all registered outputs:
- `vga_x` out 8
- `vga_y` out 7
- `vga_colour` out 3
- `vga_plot` out 1
REQ-007 SHALL have `drop_count`, out, 8 bits: clipped-pixel count.
REQ-008 SHALL have `fifo_count`, out, 3 bits: FIFO occupancy, 0..4.

Function
REQ-009 SHALL buffer accepted pixels in a 4-entry FIFO, 18-bit entries {x,y,colour}.
REQ-010 SHALL drive `blk_ready`/`ply_ready` combinationally; at most one high per cycle; both low when `fifo_count`==4.
- Full FIFO with simultaneous pop still blocks acceptance.
REQ-011 SHALL grant when exactly one port is valid and FIFO not full: that port.
REQ-012 SHALL grant when both ports are valid and FIFO not full: the port named by 1-bit priority pointer `pri` (0=blk, 1=ply).
- `pri` flips after every two-way-contended grant.
- `pri` is unchanged on uncontended grants.
REQ-013 SHALL complete a handshake when valid&&ready at a rising edge.
REQ-014 SHALL push an accepted pixel into the FIFO only if x<160 and y<120.
REQ-015 SHALL discard an accepted pixel with x>=160 or y>=120 (no push) and increment `drop_count`.
- `drop_count` saturates at 255.
REQ-016 SHALL pop the FIFO head at an edge where `hold`==0 and the FIFO is non-empty.
REQ-017 SHALL, at each pop edge, load `vga_x`/`vga_y`/`vga_colour` with the head entry and set `vga_plot`=1.
REQ-018 SHALL, at any edge without a pop, set `vga_plot`=0 and hold `vga_x`/`vga_y`/`vga_colour`.
REQ-019 SHALL, on a simultaneous push and pop with FIFO non-full, perform both.
- `fifo_count` unchanged.
- Ordering preserved.
REQ-020 SHALL have latency: a pixel accepted at edge N into an empty FIFO, with `hold` low, appears with `vga_plot`=1 after edge N+1.
REQ-021 SHALL preserve acceptance order at the output; read/write pointers wrap modulo 4.
REQ-022 SHALL sustain throughput of one pixel per cycle with `hold` low.
REQ-023 SHALL, while `hold`==1, continue accepting until full; FIFO contents are retained.

Reset
REQ-024 SHALL, when `reset`==0 at an edge, set all of the following to 0, overriding any handshake or pop that cycle:
- `vga_x`, `vga_y`, `vga_colour`, `vga_plot`
- `drop_count`, `fifo_count`
- FIFO pointers
- `pri` (block port first)
REQ-025 SHALL keep `blk_ready`/`ply_ready` low while `reset`==0.
REQ-026 SHALL discard mid-stream FIFO contents on reset.

Verification
REQ-027 SHALL cover single pixel: `blk_valid`=1 with (20,7,3'b100) for one cycle, `hold`=0 -> `blk_ready`=1 that cycle; two edges later `vga_plot`=1 with x=20, y=7, colour=4 for exactly one cycle.
REQ-028 SHALL cover contention: both ports valid continuously, `hold`=0 -> grants alternate blk, ply, blk, ply; output order matches; `vga_plot` high every cycle after fill.
REQ-029 SHALL cover full: `hold`=1, `blk_valid`=1 for 6 cycles -> 4 accepted, `fifo_count`=4, `blk_ready`=0 on cycles 5-6; release `hold` -> 4 plots in order, one per cycle.
REQ-030 SHALL cover clipping: `ply_valid` with x=165 y=10, then x=10 y=120 -> both handshakes complete, `drop_count`=2, no `vga_plot`.
- 300 clipped pixels -> `drop_count`=255.
REQ-031 SHALL cover reset mid-operation: FIFO holds 3 entries, `reset`=0 for one edge -> `fifo_count`=0, `vga_plot`=0; no stale pixel plotted afterwards.
